// File: rtl/fxu_reservation_station.sv
// rtl/fxu_reservation_station.sv - FXU reservation station with ROB snoop wakeup and oldest-ready issue
//
// Purpose: holds up to DEPTH dispatched FXU ops, wakes pending operands from the
// ROB output bus, and issues the oldest fully-ready op over a valid/ready handshake.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   flush                      synchronous invalidate of all entries
//   in_instr_valid, in_*       dispatch bundle (rob idx, opcode, imm, operands A/B)
//   rob_output_valid_flat      ROB result valids, slot k at bit 15-k
//   rob_output_values_flat     ROB result values, slot k at bits [16*(15-k) +: 16]
//   full                       station cannot accept a dispatch this cycle
//   out_valid, out_ready       issue handshake to the ALU
//   out_rob_idx .. out_b       issued op fields
//   count                      number of occupied entries
//
// Optional feature macro: RS_DISPATCH_BYPASS_EN
//   When defined, an operand dispatched not-valid whose owner slot is valid on the
//   ROB bus in the same cycle is written valid with the bus value.

module fxu_reservation_station #(
   parameter int DEPTH    = 4,
   parameter int ROB_SIZE = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    in_instr_valid,
   input  logic [3:0]              in_rob_idx,
   input  logic [3:0]              in_opcode,
   input  logic [7:0]              in_i,
   input  logic                    in_a_valid,
   input  logic [15:0]             in_a_value,
   input  logic [3:0]              in_a_owner,
   input  logic                    in_b_valid,
   input  logic [15:0]             in_b_value,
   input  logic [3:0]              in_b_owner,
   input  logic [ROB_SIZE-1:0]     rob_output_valid_flat,
   input  logic [16*ROB_SIZE-1:0]  rob_output_values_flat,
   output logic                    full,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [3:0]              out_rob_idx,
   output logic [3:0]              out_opcode,
   output logic [7:0]              out_i,
   output logic [15:0]             out_a,
   output logic [15:0]             out_b,
   output logic [3:0]              count
);

   typedef struct packed {
      logic [3:0]  rob;
      logic [3:0]  op;
      logic [7:0]  imm;
      logic        a_v;
      logic [15:0] a;
      logic [3:0]  a_own;
      logic        b_v;
      logic [15:0] b;
      logic [3:0]  b_own;
   } entry_t;

   entry_t           ent_q   [DEPTH];
   entry_t           ent_d   [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   // older_q[j][i] = 1 means entry j is older than entry i; only meaningful
   // when both are valid, and rows/columns are rebuilt whenever a slot is reused.
   logic [DEPTH-1:0] older_q [DEPTH];
   logic [DEPTH-1:0] older_d [DEPTH];
   logic [3:0]       count_q, count_d;

   logic [DEPTH-1:0] ready, sel, free_sel;
   logic             free_found, dispatch, issue;
   entry_t           new_ent;

   assign full  = (count_q == 4'(DEPTH));
   assign count = count_q;

   always_comb begin
      // oldest ready entry: ready and no other ready entry is older
      for (int i = 0; i < DEPTH; i++) begin
         ready[i] = vld_q[i] & ent_q[i].a_v & ent_q[i].b_v;
      end
      for (int i = 0; i < DEPTH; i++) begin
         sel[i] = ready[i];
         for (int j = 0; j < DEPTH; j++) begin
            if (j != i && ready[j] && older_q[j][i]) sel[i] = 1'b0;
         end
      end

      out_valid   = |ready;
      out_rob_idx = '0;
      out_opcode  = '0;
      out_i       = '0;
      out_a       = '0;
      out_b       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (sel[i]) begin
            out_rob_idx = ent_q[i].rob;
            out_opcode  = ent_q[i].op;
            out_i       = ent_q[i].imm;
            out_a       = ent_q[i].a;
            out_b       = ent_q[i].b;
         end
      end
      issue = out_valid & out_ready;

      free_sel   = '0;
      free_found = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!vld_q[i] && !free_found) begin
            free_sel[i] = 1'b1;
            free_found  = 1'b1;
         end
      end
      dispatch = in_instr_valid & ~full;

      new_ent.rob   = in_rob_idx;
      new_ent.op    = in_opcode;
      new_ent.imm   = in_i;
      new_ent.a_v   = in_a_valid;
      new_ent.a     = in_a_value;
      new_ent.a_own = in_a_owner;
      new_ent.b_v   = in_b_valid;
      new_ent.b     = in_b_value;
      new_ent.b_own = in_b_owner;
`ifdef RS_DISPATCH_BYPASS_EN
      if (!in_a_valid && rob_output_valid_flat[~in_a_owner]) begin
         new_ent.a_v = 1'b1;
         new_ent.a   = rob_output_values_flat[{~in_a_owner, 4'b0000} +: 16];
      end
      if (!in_b_valid && rob_output_valid_flat[~in_b_owner]) begin
         new_ent.b_v = 1'b1;
         new_ent.b   = rob_output_values_flat[{~in_b_owner, 4'b0000} +: 16];
      end
`endif

      vld_d = vld_q;
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i]   = ent_q[i];
         older_d[i] = older_q[i];
      end

      // wakeup: slot k of the bus lives at bit 15-k, i.e. ~k for a 4-bit index
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i] && !ent_q[i].a_v && rob_output_valid_flat[~ent_q[i].a_own]) begin
            ent_d[i].a_v = 1'b1;
            ent_d[i].a   = rob_output_values_flat[{~ent_q[i].a_own, 4'b0000} +: 16];
         end
         if (vld_q[i] && !ent_q[i].b_v && rob_output_valid_flat[~ent_q[i].b_own]) begin
            ent_d[i].b_v = 1'b1;
            ent_d[i].b   = rob_output_values_flat[{~ent_q[i].b_own, 4'b0000} +: 16];
         end
      end

      if (issue) vld_d = vld_d & ~sel;

      // new entry is younger than everything currently held
      for (int i = 0; i < DEPTH; i++) begin
         if (dispatch && free_sel[i]) begin
            ent_d[i]   = new_ent;
            vld_d[i]   = 1'b1;
            older_d[i] = '0;
            for (int j = 0; j < DEPTH; j++) begin
               older_d[j][i] = vld_q[j];
            end
         end
      end

      count_d = count_q + {3'b000, dispatch} - {3'b000, issue};
      if (flush) begin
         vld_d   = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q   <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i]   <= '0;
            older_q[i] <= '0;
         end
      end else begin
         vld_q   <= vld_d;
         count_q <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i]   <= ent_d[i];
            older_q[i] <= older_d[i];
         end
      end
   end

endmodule

// File: doc/fxu_reservation_station.md
Name: fxu_reservation_station

Overview:
- Receiving end of one FXU dispatch channel from the instruction buffer (the out_fxu_N_* bundle); it drives the matching fxu_N_full back.
- Holds up to DEPTH dispatched FXU ops and snoops the ROB output bus to wake up pending operands.
- Issues the oldest fully-ready op to the FXU ALU over a valid/ready handshake.
- One instance per FXU (fxu_0, fxu_1).

Parameters:
- DEPTH, 4, number of station entries (2..8)
- ROB_SIZE, 16, ROB entries snooped; fixed at 16 by bus width

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous: invalidate all entries
- in_instr_valid  in  1  dispatch strobe
- in_rob_idx  in  4  ROB slot of the op
- in_opcode  in  4  FXU opcode
- in_i  in  8  immediate
- in_a_valid  in  1  operand A already has its value
- in_a_value  in  16  operand A value
- in_a_owner  in  4  ROB slot producing A
- in_b_valid, in_b_value, in_b_owner  in  1/16/4  same as A, for operand B
- rob_output_valid_flat  in  16  ROB result valid; slot k is bit 15-k
- rob_output_values_flat  in  256  ROB results; slot k is bits [16*(15-k)+15 : 16*(15-k)]
- full  out  1  station cannot accept a dispatch this cycle
- out_valid  out  1  issue request to ALU
- out_ready  in  1  ALU accepts
- out_rob_idx  out  4  issued op's ROB slot
- out_opcode  out  4  issued op's opcode
- out_i  out  8  issued op's immediate
- out_a  out  16  issued op's operand A
- out_b  out  16  issued op's operand B
- count  out  4  number of occupied entries

Behaviour:
- Reset (async, rst high): all entries invalid; count=0; full=0; out_valid=0; out_* data=0. State holds until rst deasserts. A reset mid-operation discards all entries, including an op presented but not yet accepted.
- full = (count == DEPTH). It is driven only from registered state, so it is stable for the whole cycle.
- Dispatch:
  - When in_instr_valid & ~full, the op is written into a free entry at posedge.
  - When in_instr_valid & full, the op is dropped. The instruction buffer guarantees this does not happen, and the bench flags it as an error.
  - Free entries are the lowest-numbered invalid slots.
- Age:
  - Each accepted op is older than every op accepted after it.
  - Relative age is preserved across issue and removal; no age wrap errors are permitted.
- Wakeup:
  - Every cycle, each valid entry with operand X not valid whose owner slot k has rob_output_valid bit (15-k)=1 captures that slot's value and sets X valid at posedge.
  - A and B wake independently.
  - Capture from the bus is idempotent.
- Ready: entry valid & a_valid & b_valid. An entry written or woken at edge N is eligible to issue from cycle N onward (one-cycle minimum residence).
- Issue:
  - out_valid=1 iff any entry is ready. out_* present the oldest ready entry, combinationally from registered state.
  - On out_valid & out_ready, that entry is invalidated at posedge.
  - While out_valid=1 & out_ready=0, the presented op must not change unless an older entry becomes ready, in which case the older op is presented instead.
  - At most one issue per cycle.
- Simultaneous events:
  - Issue and dispatch in the same cycle: count is unchanged, and a full station stays full for that cycle.
  - Wakeup of an entry being dispatched is handled by the optional feature.
- Flush: all entries are invalidated at posedge. Flush overrides a same-cycle dispatch and issue; the ALU must treat an issue during flush as squashed.
- count always equals the number of valid entries; it is never >DEPTH and never underflows.

Optional Feature:
- RS_DISPATCH_BYPASS_EN defined: during a dispatch cycle, an incoming operand with in_X_valid=0 whose owner's ROB slot is valid on the bus that same cycle is written as valid with the bus value. The op can then issue the next cycle.
- Not defined: the operand is written invalid and is captured on the following cycle's snoop, costing one extra cycle. The ROB holds results valid until retirement, so no wakeup is lost.

Test Plan:
- Reset then idle: rst pulse mid-cycle -> full=0, count=0, out_valid=0 immediately. Dispatch {rob 3, opcode 0, a=5 valid, b=7 valid} with out_ready=1 -> out_valid at next cycle, out_rob_idx=3, out_a=5, out_b=7, then count=0.
- Fill/full: DEPTH=4 dispatches with b pending, owner 9 -> count=4, full=1, out_valid=0. Then set rob_output_valid bit 6 (slot 9) with value 0x00AA -> all four issue oldest-first on consecutive cycles with out_b=0x00AA, and full drops after the first issue.
- Out-of-order issue: entry0 waits on slot 2, entry1 ready -> entry1 issues first. Then wake slot 2 -> entry0 issues.
- Backpressure: out_ready=0 for 3 cycles with an op presented -> outputs stable, count unchanged. Then dispatch an older-than-nothing newer ready op -> presentation does not switch to the newer op.
- Full with simultaneous issue+dispatch: count=4 and out_ready=1 while in_instr_valid=1 -> dispatch dropped (full=1 that cycle), count=3.
- Bypass: dispatch with a owner 4 while slot 4 is valid (value 0x1234) that cycle -> issue next cycle with out_a=0x1234 when RS_DISPATCH_BYPASS_EN is defined, one cycle later when it is not. Flush during a pending op -> count=0 next cycle.
